// File: rtl/wb_dram_user_port_responder_pkg.sv
// Shared widths, FSM state type and saturating counter helper for the DRAM user-port stand-in.
// Pure declarations: no latency, no handshake.
package wb_dram_model_pkg;
   localparam int ADR_W = 25;
   localparam int DAT_W = 256;
   localparam int SEL_W = 32;

   typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} resp_state_t;

   typedef logic [15:0] cnt16_t;

   function automatic cnt16_t sat_inc(input cnt16_t c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction
endpackage

// File: rtl/wb_dram_user_port_responder_if.sv
// Wishbone classic bus between a test initiator and the DRAM user-port stand-in.
// Request held by the initiator until wb_ack or wb_err; no other backpressure.
interface wb_dram_user_port_responder_if;
   import wb_dram_model_pkg::*;

   logic [ADR_W-1:0] wb_adr;
   logic [DAT_W-1:0] wb_dat_w;
   logic [SEL_W-1:0] wb_sel;
   logic             wb_cyc;
   logic             wb_stb;
   logic             wb_we;
   logic             wb_ack;
   logic             wb_err;
   logic [DAT_W-1:0] wb_dat_r;

   modport master (
      output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
      input  wb_ack, wb_err, wb_dat_r
   );

   modport slave (
      input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
      output wb_ack, wb_err, wb_dat_r
   );
endinterface

// File: rtl/wb_dram_user_port_responder_bram.sv
// Single-port DEPTH x 256 byte-writable RAM, read data registered one cycle after en.
// No reset and no handshake; the read register holds its value while en is low.
module wb_dram_model_bram
   import wb_dram_model_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic [SEL_W-1:0] we,
   input  logic [AW-1:0]    addr,
   input  logic [DAT_W-1:0] din,
   output logic [DAT_W-1:0] dout
);
   logic [DAT_W-1:0] mem [DEPTH];
   logic [DAT_W-1:0] rd_dat_q;

   // Read-first: a write edge returns the old word, which the top never uses.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < SEL_W; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
         end
         rd_dat_q <= mem[addr];
      end
   end

   assign dout = rd_dat_q;
endmodule

// File: rtl/wb_dram_user_port_responder.sv
// Wishbone responder replacing the DRAM controller user port: ack/err at E0+1+latency after accept.
// Requests wait (unacked) during init; dropping wb_cyc while waiting abandons the request.
module wb_dram_user_port_responder
   import wb_dram_model_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int RD_LATENCY  = 4,
   parameter int WR_LATENCY  = 2,
   parameter int INIT_CYCLES = 64,
   parameter bit INIT_ERROR  = 1'b0
) (
   input  logic                          user_clk,
   input  logic                          user_rst,
   wb_dram_user_port_responder_if.slave  wb,
   output logic                          init_done,
   output logic                          init_error,
   output cnt16_t                        wr_count,
   output cnt16_t                        rd_count
);
   localparam int               AW        = $clog2(DEPTH);
   localparam logic [ADR_W-1:0] DEPTH_A   = ADR_W'(DEPTH);
   localparam logic [7:0]       RD_LAT    = 8'(RD_LATENCY);
   localparam logic [7:0]       WR_LAT    = 8'(WR_LATENCY);
   localparam logic [31:0]      INIT_LAST = 32'(INIT_CYCLES - 1);

   resp_state_t      state_q, state_d;
   logic [31:0]      init_cnt_q, init_cnt_d;
   logic [7:0]       lat_q, lat_d;
   logic [AW-1:0]    adr_q, adr_d;
   logic [DAT_W-1:0] dat_q, dat_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             we_q, we_d;
   logic             bad_q, bad_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             ierr_q, ierr_d;
   cnt16_t           wr_cnt_q, wr_cnt_d;
   cnt16_t           rd_cnt_q, rd_cnt_d;

   logic             ram_en;
   logic [SEL_W-1:0] ram_we;
   logic [AW-1:0]    ram_addr;
   logic [DAT_W-1:0] ram_dout;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      lat_d      = lat_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      sel_d      = sel_q;
      we_d       = we_q;
      bad_d      = bad_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      done_d     = done_q;
      ierr_d     = ierr_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      ram_en     = 1'b0;
      ram_we     = '0;
      ram_addr   = adr_q;

      case (state_q)
         INIT: begin
            if (init_cnt_q == INIT_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
               ierr_d  = INIT_ERROR;
            end else begin
               init_cnt_d = init_cnt_q + 32'd1;
            end
         end
         IDLE: begin
            // The RAM read is launched here so its output is stable through WAIT.
            if (wb.wb_cyc && wb.wb_stb) begin
               adr_d    = wb.wb_adr[AW-1:0];
               dat_d    = wb.wb_dat_w;
               sel_d    = wb.wb_sel;
               we_d     = wb.wb_we;
               bad_d    = (wb.wb_adr >= DEPTH_A);
               lat_d    = wb.wb_we ? WR_LAT : RD_LAT;
               ram_en   = 1'b1;
               ram_addr = wb.wb_adr[AW-1:0];
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (!wb.wb_cyc) begin
               state_d = IDLE;
            end else if (lat_q == 8'd0) begin
               state_d = RESP;
               if (bad_q) begin
                  err_d = 1'b1;
               end else begin
                  ack_d = 1'b1;
                  if (we_q) begin
                     ram_en   = 1'b1;
                     ram_we   = sel_q;
                     wr_cnt_d = sat_inc(wr_cnt_q);
                  end else begin
                     rd_cnt_d = sat_inc(rd_cnt_q);
                  end
               end
            end else begin
               lat_d = lat_q - 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         lat_q      <= '0;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         bad_q      <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         ierr_q     <= 1'b0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         lat_q      <= lat_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         bad_q      <= bad_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         done_q     <= done_d;
         ierr_q     <= ierr_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

   wb_dram_model_bram #(.DEPTH(DEPTH), .AW(AW)) u_bram (
      .clk  (user_clk),
      .en   (ram_en),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (dat_q),
      .dout (ram_dout)
   );

   assign wb.wb_ack   = ack_q;
   assign wb.wb_err   = err_q;
   assign wb.wb_dat_r = (ack_q && !we_q) ? ram_dout : '0;
   assign init_done   = done_q;
   assign init_error  = ierr_q;
   assign wr_count    = wr_cnt_q;
   assign rd_count    = rd_cnt_q;
endmodule

// File: tb/tb_wb_dram_user_port_responder.sv
// Bench: transaction-level memory model (associative array + due-cycle timing) checked every cycle,
// plus directed literal checks for init timing, latency, byte masks, errors, abort and reset.
module tb_wb_dram_user_port_responder;
   localparam int DEPTH       = 1024;
   localparam int RD_LATENCY  = 4;
   localparam int WR_LATENCY  = 2;
   localparam int INIT_CYCLES = 64;
   localparam bit INIT_ERROR  = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_done, init_error;
   logic [15:0] wr_count, rd_count;

   int ncmp = 0;
   int nbad = 0;

   wb_dram_user_port_responder_if bus();

   wb_dram_user_port_responder #(
      .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY), .WR_LATENCY(WR_LATENCY),
      .INIT_CYCLES(INIT_CYCLES), .INIT_ERROR(INIT_ERROR)
   ) dut (
      .user_clk   (clk),
      .user_rst   (rst),
      .wb         (bus),
      .init_done  (init_done),
      .init_error (init_error),
      .wr_count   (wr_count),
      .rd_count   (rd_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [255:0] mmem [int];
   int unsigned  ecnt;
   int unsigned  m_due;
   logic         m_busy, m_we, m_bad, m_rknown, was_resp;
   logic [24:0]  m_adr;
   logic [255:0] m_wd, m_rdat;
   logic [31:0]  m_sel;
   logic         e_ack, e_err, e_dknown;
   logic [255:0] e_dat;
   logic [15:0]  e_wr, e_rd;

   task automatic mem_write(input int a, input logic [255:0] d, input logic [31:0] s);
      logic [255:0] w;
      if (s == 32'hFFFFFFFF) begin
         mmem[a] = d;
      end else if (s != 32'h0) begin
         if (mmem.exists(a)) begin
            w = mmem[a];
            for (int i = 0; i < 32; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
            mmem[a] = w;
         end
      end
   endtask

   initial begin : model
      ecnt = 0; m_busy = 0; e_ack = 0; e_err = 0; e_dat = '0; e_dknown = 1; e_wr = 0; e_rd = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            ecnt = 0; m_busy = 0; e_ack = 0; e_err = 0; e_dat = '0; e_dknown = 1;
            e_wr = 0; e_rd = 0;
         end else begin
            ecnt++;
            was_resp = e_ack | e_err;
            e_ack = 0; e_err = 0; e_dat = '0; e_dknown = 1;
            if (m_busy) begin
               if (!bus.wb_cyc) begin
                  m_busy = 0;
               end else if (ecnt == m_due) begin
                  m_busy = 0;
                  if (m_bad) begin
                     e_err = 1;
                  end else if (m_we) begin
                     e_ack = 1;
                     e_wr  = (e_wr == 16'hFFFF) ? e_wr : e_wr + 16'd1;
                     mem_write(int'(m_adr), m_wd, m_sel);
                  end else begin
                     e_ack    = 1;
                     e_rd     = (e_rd == 16'hFFFF) ? e_rd : e_rd + 16'd1;
                     e_dat    = m_rdat;
                     e_dknown = m_rknown;
                  end
               end
            end else if (!was_resp && ecnt > INIT_CYCLES && bus.wb_cyc && bus.wb_stb) begin
               m_busy   = 1;
               m_we     = bus.wb_we;
               m_adr    = bus.wb_adr;
               m_wd     = bus.wb_dat_w;
               m_sel    = bus.wb_sel;
               m_bad    = (int'(bus.wb_adr) >= DEPTH);
               m_due    = ecnt + 1 + (bus.wb_we ? WR_LATENCY : RD_LATENCY);
               m_rknown = !m_bad && mmem.exists(int'(bus.wb_adr));
               m_rdat   = m_rknown ? mmem[int'(bus.wb_adr)] : '0;
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("ack", 256'(bus.wb_ack), 256'(e_ack));
         chk("err", 256'(bus.wb_err), 256'(e_err));
         if (e_dknown) chk("dat_r", bus.wb_dat_r, e_dat);
         chk("init_done", 256'(init_done), 256'(ecnt >= INIT_CYCLES));
         chk("init_error", 256'(init_error), 256'((ecnt >= INIT_CYCLES) && INIT_ERROR));
         chk("wr_count", 256'(wr_count), 256'(e_wr));
         chk("rd_count", 256'(rd_count), 256'(e_rd));
      end
   end

   // ---------------- driver ----------------
   task automatic txn(input logic we, input logic [24:0] adr, input logic [255:0] d,
                      input logic [31:0] sel, input int abort_at,
                      output logic g_ack, output logic g_err, output logic [255:0] g_dat,
                      output int g_edges);
      bit done;
      bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
      bus.wb_adr = adr; bus.wb_dat_w = d; bus.wb_sel = sel;
      g_ack = 0; g_err = 0; g_dat = '0; g_edges = 0; done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         g_edges++;
         if (bus.wb_ack || bus.wb_err) begin
            g_ack = bus.wb_ack; g_err = bus.wb_err; g_dat = bus.wb_dat_r; done = 1;
         end else if (i == abort_at) begin
            done = 1;
         end
      end
      bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
      if (abort_at < 0) chk("txn_completes", 256'(g_ack | g_err), 256'(1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      logic         ga, ge;
      logic [255:0] gd, exp_d;
      int           ged, ack_edge;
      logic [24:0]  ra;
      logic [31:0]  rs;
      bit           done;

      bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
      bus.wb_adr = '0; bus.wb_dat_w = '0; bus.wb_sel = '0;
      do_reset();

      // Init sequencing with a request held from cycle 10.
      repeat (10) @(negedge clk);
      bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_we = 1; bus.wb_adr = 25'd5;
      bus.wb_dat_w = {32{8'h3C}}; bus.wb_sel = 32'hFFFFFFFF;
      ack_edge = 0; done = 0;
      for (int k = 11; k < 200 && !done; k++) begin
         @(negedge clk);
         if (k == 63) chk("init_done_at_63", 256'(init_done), 256'(0));
         if (k == 64) begin
            chk("init_done_at_64", 256'(init_done), 256'(1));
            chk("init_error_at_64", 256'(init_error), 256'(0));
         end
         if (bus.wb_ack || bus.wb_err) begin ack_edge = k; done = 1; end
      end
      bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
      chk("held_req_ack_edge", 256'(ack_edge), 256'(68));
      @(negedge clk);

      // Full write then read of adr 0.
      txn(1, 25'd0, {32{8'hA5}}, 32'hFFFFFFFF, -1, ga, ge, gd, ged);
      chk("wr0_ack", 256'(ga), 256'(1));
      chk("wr0_edges", 256'(ged), 256'(4));
      @(negedge clk);
      txn(0, 25'd0, '0, 32'h0, -1, ga, ge, gd, ged);
      chk("rd0_edges", 256'(ged), 256'(6));
      chk("rd0_dat", gd, {32{8'hA5}});
      chk("wr_count_2", 256'(wr_count), 256'(2));
      chk("rd_count_1", 256'(rd_count), 256'(1));
      @(negedge clk);

      // Partial byte-lane write.
      txn(1, 25'd7, {32{8'h5A}}, 32'hFFFFFFFF, -1, ga, ge, gd, ged);
      @(negedge clk);
      txn(1, 25'd7, {32{8'hFF}}, 32'h0000000F, -1, ga, ge, gd, ged);
      @(negedge clk);
      txn(0, 25'd7, '0, 32'h0, -1, ga, ge, gd, ged);
      exp_d = {{28{8'h5A}}, {4{8'hFF}}};
      chk("rd7_masked", gd, exp_d);
      @(negedge clk);

      // Out-of-range address.
      txn(0, 25'd1024, '0, 32'h0, -1, ga, ge, gd, ged);
      chk("oor_err", 256'(ge), 256'(1));
      chk("oor_ack", 256'(ga), 256'(0));
      chk("oor_dat", gd, 256'(0));
      chk("oor_wr_count", 256'(wr_count), 256'(4));
      chk("oor_rd_count", 256'(rd_count), 256'(2));
      @(negedge clk);

      // Abort during WAIT, then a normal read.
      txn(0, 25'd0, '0, 32'h0, 1, ga, ge, gd, ged);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("abort_no_resp", 256'(bus.wb_ack | bus.wb_err), 256'(0));
      end
      txn(0, 25'd0, '0, 32'h0, -1, ga, ge, gd, ged);
      chk("post_abort_dat", gd, {32{8'hA5}});
      chk("post_abort_rd_count", 256'(rd_count), 256'(3));
      @(negedge clk);

      // Preload a small address window, then randomized traffic.
      for (int a = 0; a < 16; a++) begin
         txn(1, 25'(a), {8{$urandom}}, 32'hFFFFFFFF, -1, ga, ge, gd, ged);
      end
      for (int n = 0; n < 150; n++) begin
         int ab;
         ra = ($urandom_range(0, 9) == 0) ? 25'(1024 + $urandom_range(0, 1023))
                                          : 25'($urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0, 1:    rs = 32'hFFFFFFFF;
            2:       rs = 32'h0;
            default: rs = $urandom;
         endcase
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
         txn(1'($urandom_range(0, 1)), ra, {8{$urandom}}, rs, ab, ga, ge, gd, ged);
         if (ab >= 0 || $urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);

      // Reset in the middle of a write's wait phase.
      txn(1, 25'd3, '0, 32'hFFFFFFFF, -1, ga, ge, gd, ged);
      @(negedge clk);
      bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_we = 1; bus.wb_adr = 25'd3;
      bus.wb_dat_w = {256{1'b1}}; bus.wb_sel = 32'hFFFFFFFF;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_ack", 256'(bus.wb_ack), 256'(0));
      chk("rst_err", 256'(bus.wb_err), 256'(0));
      chk("rst_dat", bus.wb_dat_r, 256'(0));
      chk("rst_init_done", 256'(init_done), 256'(0));
      chk("rst_wr_count", 256'(wr_count), 256'(0));
      chk("rst_rd_count", 256'(rd_count), 256'(0));
      bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (init_done) done = 1;
      end
      chk("reinit_done", 256'(init_done), 256'(1));
      @(negedge clk);
      txn(0, 25'd3, '0, 32'h0, -1, ga, ge, gd, ged);
      chk("rd3_after_rst", gd, 256'(0));
      chk("rd3_rd_count", 256'(rd_count), 256'(1));
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
